// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// Handshake: the fetch stage holds imem_req=1 with a stable imem_addr until the
// memory raises imem_ready for one cycle; imem_rdata is valid only in that cycle.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    // Fetch-stage side: drives the request, receives the word.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    // Memory side: observes the request, returns the word.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per REQ/HOLD round,
// holds it for decode/execute and computes the next PC from decoder controls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clock,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic [1:0]        pcsel,
    input  logic              br_taken,
    input  logic [31:0]       jalr_target,
    input  logic              stall,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic              fetch_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        req;
    logic        load_instr;
    logic        advance;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] next_pc;

    assign state          = state_q;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    assign pc_plus4 = pc + 32'd4;
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];

    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Next-PC selection; jalr clears bit 0 before the alignment check.
    always_comb begin
        next_pc = pc_plus4;
        case (pcsel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = jalr_target & ~32'h0000_0001;
            2'b10: next_pc = br_taken ? (pc + imm_b) : pc_plus4;
            2'b11: next_pc = pc + imm_j;
            default: next_pc = pc_plus4;
        endcase
    end

    // State register; reset aborts any outstanding request immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_d     = state_q;
        req         = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        load_instr  = 1'b0;
        advance     = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    load_instr = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    advance = 1'b1;
                    state_d = (next_pc[1:0] != 2'b00) ? HALT : REQ;
                end
            end
            HALT: begin
                // Sticky: only reset leaves HALT, so the flag stays set.
                fetch_err = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // PC and instruction register; a misaligned target is still loaded so
    // the PC shows the offending address while halted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else if (load_instr) begin
            instr <= imem.imem_rdata;
        end else if (advance) begin
            pc    <= next_pc;
            instr <= NOP_INSTR;
        end
    end

endmodule
